// File: rtl/mul_seq.sv
`default_nettype none
// ============================================================================
//  Module      : mul_seq
//  Description : Sequential radix-2 shift-add multiplier for the MULT/MULTU
//                path. Produces a 2*WIDTH-bit product split into hi/lo,
//                one multiplier bit per clock, with a start/busy/done
//                handshake.
//  Ports       : clk          - rising-edge clock
//                reset        - synchronous, active-high reset
//                start        - request pulse, sampled only in IDLE
//                op           - 2'b10 unsigned, 2'b11 signed, others reserved
//                multiplicand - operand A
//                multiplier   - operand B
//                hi / lo      - registered upper / lower product halves
//                busy         - high whenever the state is not IDLE
//                done         - one-cycle pulse when hi/lo are newly updated
//  Revision    : 1.0 - initial release
// ============================================================================
module mul_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] multiplicand,
    input  logic [WIDTH-1:0] multiplier,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] c_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] c_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t             r_state_q, w_state_d;
    logic [WIDTH-1:0]   r_mcand_q, w_mcand_d;
    logic [WIDTH-1:0]   r_mplier_q, w_mplier_d;
    logic [2*WIDTH-1:0] r_acc_q, w_acc_d;
    logic [CNT_W-1:0]   r_cnt_q, w_cnt_d;
    logic               r_neg_q, w_neg_d;
    logic [WIDTH-1:0]   r_hi_q, w_hi_d;
    logic [WIDTH-1:0]   r_lo_q, w_lo_d;

    logic               w_signed;
    logic [WIDTH-1:0]   w_abs_a;
    logic [WIDTH-1:0]   w_abs_b;
    logic [WIDTH:0]     w_sum;
    logic [2*WIDTH-1:0] w_fixed;

    // Signed operands are reduced to magnitudes; the most-negative value
    // negates to itself, which read as unsigned is exactly its magnitude.
    assign w_signed = op[0];
    assign w_abs_a  = (w_signed && multiplicand[WIDTH-1]) ? (-multiplicand) : multiplicand;
    assign w_abs_b  = (w_signed && multiplier[WIDTH-1])   ? (-multiplier)   : multiplier;

    // Partial-sum adder keeps the carry so the upper half never overflows.
    assign w_sum   = {1'b0, r_acc_q[2*WIDTH-1:WIDTH]}
                   + {1'b0, (r_mplier_q[0] ? r_mcand_q : {WIDTH{1'b0}})};
    assign w_fixed = r_neg_q ? (-r_acc_q) : r_acc_q;

    always_comb begin
        w_state_d  = r_state_q;
        w_mcand_d  = r_mcand_q;
        w_mplier_d = r_mplier_q;
        w_acc_d    = r_acc_q;
        w_cnt_d    = r_cnt_q;
        w_neg_d    = r_neg_q;
        w_hi_d     = r_hi_q;
        w_lo_d     = r_lo_q;

        case (r_state_q)
            S_IDLE: begin
                if (start && op[1]) begin
                    w_mcand_d  = w_abs_a;
                    w_mplier_d = w_abs_b;
                    w_neg_d    = w_signed & (multiplicand[WIDTH-1] ^ multiplier[WIDTH-1]);
                    w_acc_d    = '0;
                    w_cnt_d    = '0;
                    w_state_d  = S_RUN;
                end
            end
            S_RUN: begin
                // {carry, upper sum, lower half} shifted right by one.
                w_acc_d    = {w_sum, r_acc_q[WIDTH-1:1]};
                w_mplier_d = r_mplier_q >> 1;
                w_cnt_d    = r_cnt_q + c_ONE;
                if (r_cnt_q == c_LAST) begin
                    w_state_d = S_FIX;
                end
            end
            S_FIX: begin
                w_hi_d    = w_fixed[2*WIDTH-1:WIDTH];
                w_lo_d    = w_fixed[WIDTH-1:0];
                w_state_d = S_DONE;
            end
            S_DONE: begin
                w_state_d = S_IDLE;
            end
            default: begin
                w_state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state_q  <= S_IDLE;
            r_mcand_q  <= '0;
            r_mplier_q <= '0;
            r_acc_q    <= '0;
            r_cnt_q    <= '0;
            r_neg_q    <= 1'b0;
            r_hi_q     <= '0;
            r_lo_q     <= '0;
        end else begin
            r_state_q  <= w_state_d;
            r_mcand_q  <= w_mcand_d;
            r_mplier_q <= w_mplier_d;
            r_acc_q    <= w_acc_d;
            r_cnt_q    <= w_cnt_d;
            r_neg_q    <= w_neg_d;
            r_hi_q     <= w_hi_d;
            r_lo_q     <= w_lo_d;
        end
    end

    assign hi   = r_hi_q;
    assign lo   = r_lo_q;
    assign busy = (r_state_q != S_IDLE);
    assign done = (r_state_q == S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_mul_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mul_seq
//  Description : Scoreboard bench for mul_seq. Issued operations push their
//                expected product and completion cycle; a monitor pops and
//                compares on every done pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mul_seq;

    localparam int WIDTH = 32;
    localparam int LAT   = WIDTH + 2;   // done cycle relative to the drive cycle

    logic             clk;
    logic             reset;
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] multiplicand;
    logic [WIDTH-1:0] multiplier;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             busy;
    logic             done;

    mul_seq #(.WIDTH(WIDTH)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .op           (op),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .hi           (hi),
        .lo           (lo),
        .busy         (busy),
        .done         (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [2*WIDTH-1:0] prod;
        int                 at;
        string              name;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic chk(input string name, input logic [2*WIDTH-1:0] act,
                       input logic [2*WIDTH-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: plain arithmetic on sign- or zero-extended operands.
    function automatic logic [2*WIDTH-1:0] ref_mul(input logic [1:0] o,
                                                   input logic [WIDTH-1:0] a,
                                                   input logic [WIDTH-1:0] b);
        longint sa, sb_;
        logic [2*WIDTH-1:0] ua, ub;
        if (o == 2'b11) begin
            sa  = longint'($signed(a));
            sb_ = longint'($signed(b));
            return 64'(sa * sb_);
        end
        ua = {{WIDTH{1'b0}}, a};
        ub = {{WIDTH{1'b0}}, b};
        return ua * ub;
    endfunction

    // Monitor: every done pulse must match the oldest outstanding operation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!reset && done) begin
                if (sb.size() == 0) begin
                    chk("unexpected_done", {63'd0, done}, 64'd0);
                end else begin
                    e = sb.pop_front();
                    chk({e.name, "_prod"}, {hi, lo}, e.prod);
                    chk({e.name, "_cycle"}, 64'(cyc), 64'(e.at));
                    chk({e.name, "_busy_at_done"}, {63'd0, busy}, 64'd1);
                end
            end
        end
    end

    // Drive a start pulse at the current (falling-edge) time; push expectation.
    task automatic issue(input string name, input logic [1:0] o,
                         input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        exp_t e;
        start        = 1'b1;
        op           = o;
        multiplicand = a;
        multiplier   = b;
        e.prod = ref_mul(o, a, b);
        e.at   = cyc + LAT;
        e.name = name;
        sb.push_back(e);
    endtask

    // Wait for all outstanding work, scrambling inputs meanwhile.
    task automatic wait_idle(input bit noisy);
        bit finished = 1'b0;
        for (int i = 0; i < 3 * LAT; i++) begin
            @(negedge clk);
            #1;
            start = 1'b0;
            if (sb.size() == 0) begin
                finished = 1'b1;
                break;
            end
            if (busy !== 1'b1) chk("busy_during_op", {63'd0, busy}, 64'd1);
            if (noisy) begin
                op           = 2'($urandom);
                multiplicand = $urandom;
                multiplier   = $urandom;
                start        = 1'($urandom);
            end
        end
        if (!finished) begin
            chk("done_timeout", 64'(sb.size()), 64'd0);
            sb.delete();
        end
        @(negedge clk);
        #1;
        chk("busy_after_done", {63'd0, busy}, 64'd0);
    endtask

    initial begin
        logic [WIDTH-1:0] hold_hi, hold_lo;
        logic [1:0]       ro;
        logic [WIDTH-1:0] ra, rb;
        int               k;

        reset = 1'b1; start = 1'b0; op = 2'b00;
        multiplicand = '0; multiplier = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_hi",   64'(hi),   64'd0);
        chk("reset_lo",   64'(lo),   64'd0);
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_done", 64'(done), 64'd0);
        reset = 1'b0;

        // Directed vectors
        @(negedge clk); issue("u34xm5", 2'b10, 32'd34, 32'hFFFFFFFB);
        wait_idle(1'b0);
        chk("u34xm5_ref", {hi, lo}, {32'h00000021, 32'hFFFFFF56});
        issue("s34xm5", 2'b11, 32'd34, 32'hFFFFFFFB);       wait_idle(1'b1);
        chk("s34xm5_ref", {hi, lo}, {32'hFFFFFFFF, 32'hFFFFFF56});
        issue("s_minmin", 2'b11, 32'h80000000, 32'h80000000); wait_idle(1'b1);
        chk("s_minmin_ref", {hi, lo}, {32'h40000000, 32'h0});
        issue("u_maxmax", 2'b10, 32'hFFFFFFFF, 32'hFFFFFFFF); wait_idle(1'b1);
        chk("u_maxmax_ref", {hi, lo}, {32'hFFFFFFFE, 32'h1});
        issue("s_m1x1", 2'b11, 32'hFFFFFFFF, 32'd1);          wait_idle(1'b1);
        chk("s_m1x1_ref", {hi, lo}, {32'hFFFFFFFF, 32'hFFFFFFFF});
        issue("s_zero", 2'b11, 32'd0, 32'h12345678);          wait_idle(1'b1);
        issue("u_zero", 2'b10, 32'd0, 32'h12345678);          wait_idle(1'b1);

        // Start while busy is ignored
        issue("u3x4", 2'b10, 32'd3, 32'd4);
        repeat (10) @(negedge clk);
        start = 1'b1; op = 2'b10; multiplicand = 32'd5; multiplier = 32'd5;
        @(negedge clk);
        start = 1'b0;
        wait_idle(1'b0);
        chk("u3x4_ref", {hi, lo}, 64'd12);

        // Reserved op is ignored
        hold_hi = hi; hold_lo = lo;
        start = 1'b1; op = 2'b01; multiplicand = 32'd7; multiplier = 32'd7;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < LAT + 4; i++) begin
            @(negedge clk);
            if (busy !== 1'b0) chk("reserved_busy", 64'(busy), 64'd0);
        end
        chk("reserved_hold", {hi, lo}, {hold_hi, hold_lo});

        // Reset mid-operation
        issue("u7x6", 2'b10, 32'd7, 32'd6); wait_idle(1'b0);
        chk("u7x6_ref", 64'(lo), 64'd42);
        issue("u9x9", 2'b10, 32'd9, 32'd9);
        repeat (15) @(negedge clk);
        start = 1'b0;
        sb.delete();
        reset = 1'b1;
        @(negedge clk);
        chk("midreset_hilo", {hi, lo}, 64'd0);
        chk("midreset_busy", 64'(busy), 64'd0);
        chk("midreset_done", 64'(done), 64'd0);
        reset = 1'b0;
        repeat (LAT + 4) @(negedge clk);
        issue("u2x3", 2'b10, 32'd2, 32'd3); wait_idle(1'b0);
        chk("u2x3_ref", 64'(lo), 64'd6);

        // Randomized operations, back-to-back, with input noise while busy
        for (int n = 0; n < 40; n++) begin
            ro = 2'b10 | 2'($urandom_range(0, 1));
            ra = $urandom;
            rb = $urandom;
            k  = $urandom_range(0, 7);
            if (k == 0) ra = 32'h80000000;
            if (k == 1) rb = 32'hFFFFFFFF;
            if (k == 2) ra = 32'd0;
            issue(ro[0] ? "rnd_s" : "rnd_u", ro, ra, rb);
            wait_idle(1'b1);
        end

        repeat (2) @(negedge clk);
        chk("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
